ref_dac_scheduler: RTL

REF_DAC_SCHEDULER -- requirements
Module: ref_dac_scheduler

---
 rtl/ref_dac_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ref_dac_scheduler.sv
// ref_dac_scheduler
//   Arbitrates four channel update requests round-robin and shifts the
//   granted 16-bit word, MSB first, to a reference DAC over a
//   chip-select / serial-clock / serial-data link.
//
// Ports
//   clk       system clock, all logic on its rising edge
//   rst       asynchronous active-high reset
//   req       per-channel request level, held until the matching ack
//   req_data  four 16-bit words, channel n at bits 16n+15:16n
//   ack       one-cycle accept pulse for the granted channel
//   busy      high while a transfer (setup, shift or gap) is in progress
//   done      one-cycle pulse when a transfer completes
//   SDI_REF   serial data, changes on CLK_REF falling edges
//   CLK_REF   serial clock, idle low, CLK_DIV clk cycles per half-period
//   CS_REF    active-low chip select per channel
//   MUX_REF   index of the channel currently/last granted
module ref_dac_scheduler #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] req_data,
    output logic [3:0]  ack,
    output logic        busy,
    output logic        done,
    output logic        SDI_REF,
    output logic        CLK_REF,
    output logic [3:0]  CS_REF,
    output logic [1:0]  MUX_REF
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [4:0]  half_cnt;    // 32 half-periods of CLK_REF per transfer
    logic [1:0]  last_grant;
    logic [15:0] shift_reg;   // bit 15 is the bit currently on SDI_REF
    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [15:0] grant_word;
    logic        div_end;

    // Search starts one past the previous winner and wraps; the fourth
    // candidate is the previous winner itself.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign grant_vld  = (state == IDLE) && (req != 4'b0000);
    assign grant_idx  = rr_pick(last_grant, req);
    assign grant_word = req_data[{grant_idx, 4'b0000} +: 16];
    assign div_end    = (div_cnt == DIV_LAST);

    // Data path only: captured at grant, advanced on each CLK_REF fall.
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            shift_reg <= grant_word;
        end else if (state == SHIFT && div_end && CLK_REF) begin
            shift_reg <= {shift_reg[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            half_cnt   <= 5'd0;
            last_grant <= 2'd3;
            ack        <= 4'b0000;
            done       <= 1'b0;
            busy       <= 1'b0;
            SDI_REF    <= 1'b0;
            CLK_REF    <= 1'b0;
            CS_REF     <= 4'b1111;
            MUX_REF    <= 2'd0;
        end else begin
            ack  <= 4'b0000;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        ack        <= 4'b0001 << grant_idx;
                        CS_REF     <= ~(4'b0001 << grant_idx);
                        SDI_REF    <= grant_word[15];
                        MUX_REF    <= grant_idx;
                        last_grant <= grant_idx;
                        div_cnt    <= 8'd0;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt  <= 8'd0;
                        half_cnt <= 5'd0;
                        CLK_REF  <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= 8'd0;
                        if (half_cnt == 5'd31) begin
                            CLK_REF <= 1'b0;
                            CS_REF  <= 4'b1111;
                            SDI_REF <= 1'b0;
                            state   <= GAP;
                        end else begin
                            half_cnt <= half_cnt + 5'd1;
                            CLK_REF  <= ~CLK_REF;
                            // Leaving a high phase: present the next bit.
                            if (CLK_REF) begin
                                SDI_REF <= shift_reg[14];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (div_end) begin
                        div_cnt <= 8'd0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
